ring_fifo_flags: RTL and testbench

//   Parametrised synchronous ring-buffer FIFO. Successor to the single-flag ring FIFO.

---
 rtl/ring_fifo_flags.sv | 104 ++++++++++
 tb/tb_ring_fifo_flags.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ring_fifo_flags.sv
// ring_fifo_flags
//   Single-clock ring-buffer FIFO with show-ahead output, a fill counter and
//   programmable almost-full / almost-empty thresholds. DEPTH may be any
//   integer >= 2: pointers wrap by explicit compare, not by masking.
//   Simultaneous read+write is accepted in every state except empty, where
//   only the write goes through.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When defined, adds sticky overflow/underflow flags and a clr_err input.
//   A set condition beats clr_err in the same cycle.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   write/datain  write request and data
//   read          pop the entry currently on dataout
//   dataout       head entry (valid only while val=1)
//   val           FIFO non-empty
//   full          count == DEPTH
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         stored entries
//   overflow      [FIFO_ERR_FLAGS_EN] sticky: write rejected
//   underflow     [FIFO_ERR_FLAGS_EN] sticky: read while empty
//   clr_err       [FIFO_ERR_FLAGS_EN] synchronous clear of both sticky flags
module ring_fifo_flags #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  val,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
`endif
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  rd_acc, wr_acc;

    // Flags are pure decodes of the registered count.
    assign val          = (count != '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A read frees a slot this cycle, so a full FIFO may still take a write.
    assign rd_acc = read & val;
    assign wr_acc = write & (~full | rd_acc);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_acc && !rd_acc)      count <= count + 1'b1;
            else if (rd_acc && !wr_acc) count <= count - 1'b1;
        end
    end

    // Storage is deliberately left unreset; val qualifies dataout.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= datain;
    end

    assign dataout = mem[rd_ptr];

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write & ~wr_acc) overflow <= 1'b1;
            else if (clr_err)    overflow <= 1'b0;
            if (read & ~val)     underflow <= 1'b1;
            else if (clr_err)    underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ring_fifo_flags.sv
module tb_ring_fifo_flags;
    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          write, read;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          val, full, almost_full, almost_empty;
    logic [CW-1:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow, underflow, clr_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] sb [$];
    logic          ovf_m = 1'b0;
    logic          udf_m = 1'b0;

    ring_fifo_flags #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .write(write),
        .datain(datain),
        .read(read),
        .dataout(dataout),
        .val(val),
        .full(full),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow(overflow),
        .underflow(underflow),
        .clr_err(clr_err),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compare all visible state against the scoreboard model.
    task automatic check_state(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".val"}, 32'(val), 32'(n != 0));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".af"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= AE));
        if (n != 0) chk({tag, ".head"}, 32'(dataout), 32'(sb[0]));
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
        chk({tag, ".udf"}, 32'(underflow), 32'(udf_m));
`endif
    endtask

    // Called at a negedge: drive one cycle of stimulus, update the model,
    // let the posedge happen, then check at the following negedge.
    task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                         input logic r, input logic c);
        logic ra, wa;
        logic [DW-1:0] exp;
        write  = w;
        datain = d;
        read   = r;
`ifdef FIFO_ERR_FLAGS_EN
        clr_err = c;
`endif
        ra = r && (sb.size() != 0);
        wa = w && ((sb.size() < DEPTH) || ra);
        if (ra) begin
            exp = sb.pop_front();
            #1 chk({tag, ".pop"}, 32'(dataout), 32'(exp));
        end
        if (wa) sb.push_back(d);
        if (w && !wa) ovf_m = 1'b1;
        else if (c)   ovf_m = 1'b0;
        if (r && !ra) udf_m = 1'b1;
        else if (c)   udf_m = 1'b0;
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
        clr_err = 1'b0;
`endif
        check_state(tag);
    endtask

    initial begin
        reset  = 1'b0;
        write  = 1'b0;
        read   = 1'b0;
        datain = '0;
`ifdef FIFO_ERR_FLAGS_EN
        clr_err = 1'b0;
`endif
        #2 check_state("reset");
        @(negedge clk);
        reset = 1'b1;
        check_state("post_reset");

        // 1: fill to full
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);

        // 2: full with read+write, then drain
        cycle("full_rw", 1'b1, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // 3: pointer wrap, 3 pushes then 3 pops, 4 rounds
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) cycle("wrap_w", 1'b1, 8'(8'h30 + k * 4 + i), 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) cycle("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // 4: empty with read+write -> only the write lands
        cycle("empty_rw", 1'b1, 8'hA5, 1'b1, 1'b0);

        // 5: fill to full, rejected writes, clear, set-beats-clear
        for (int i = 0; i < DEPTH - 1; i++) cycle("refill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
        cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("ovf_clr", 1'b1, 8'hEF, 1'b0, 1'b1);

        // 6: async reset mid-cycle at count=3
        cycle("pre_rst_r", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("pre_rst_r", 1'b0, 8'h00, 1'b1, 1'b0);
        #2 reset = 1'b0;
        sb.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        #1 check_state("async_rst");
        @(negedge clk);
        reset = 1'b1;
        cycle("after_rst", 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle("after_rst_r", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
